// File: rtl/alu_iter_if.sv
// Operand/result handshake bundle for alu_iter: request side (op, operands)
// and response side (result, flags), each with valid/ready.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;
  logic             zero;
  logic             illegal;
  logic             busy;

  modport master (
    output in_valid, op, in0, in1, out_ready,
    input  in_ready, out_valid, result, carry, overflow, zero, illegal, busy
  );

  modport slave (
    input  in_valid, op, in0, in1, out_ready,
    output in_ready, out_valid, result, carry, overflow, zero, illegal, busy
  );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle WIDTH-bit ALU: single-cycle logic/arith ops, bit-serial shifts.
// Define ALU_ITER_SRA_EN to implement opcode 1000 as arithmetic right shift.
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_iter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_SLT = 4'b0100;
  localparam logic [3:0] OP_NOR = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;
`ifdef ALU_ITER_SRA_EN
  localparam logic [3:0] OP_SRA = 4'b1000;
`endif

  localparam logic [SHAMT_W-1:0] CNT_ZERO = SHAMT_W'(0);
  localparam logic [SHAMT_W-1:0] CNT_ONE  = SHAMT_W'(1);

  // One-bit shift step; returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] o, input logic [WIDTH-1:0] v);
    case (o)
      OP_SLL:  shift_step = {v[WIDTH-1], v[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_step = {v[0], 1'b0, v[WIDTH-1:1]};
`ifdef ALU_ITER_SRA_EN
      OP_SRA:  shift_step = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
`endif
      default: shift_step = {1'b0, v};
    endcase
  endfunction

  logic [1:0]         state_r, state_nxt_s;
  logic [3:0]         op_r, op_nxt_s;
  logic [SHAMT_W-1:0] cnt_r, cnt_nxt_s;
  logic [WIDTH-1:0]   result_r, result_nxt_s;
  logic               carry_r, carry_nxt_s;
  logic               overflow_r, overflow_nxt_s;
  logic               zero_r, zero_nxt_s;
  logic               illegal_r, illegal_nxt_s;

  logic               in_ready_s;
  logic               accept_s;
  logic               sub_s;
  logic [WIDTH-1:0]   b_s;
  logic [WIDTH:0]     sum_s;
  logic               ovf_s;
  logic               slt_s;
  logic [SHAMT_W-1:0] shamt_s;
  logic [WIDTH:0]     first_s;
  logic [WIDTH:0]     iter_s;

  assign in_ready_s = (state_r == S_IDLE) || ((state_r == S_DONE) && bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // SUB and SLT share the adder as in0 + ~in1 + 1.
  assign sub_s   = (bus.op == OP_SUB) || (bus.op == OP_SLT);
  assign b_s     = sub_s ? ~bus.in1 : bus.in1;
  assign sum_s   = {1'b0, bus.in0} + {1'b0, b_s} + {{WIDTH{1'b0}}, sub_s};
  assign ovf_s   = (bus.in0[WIDTH-1] == b_s[WIDTH-1]) && (sum_s[WIDTH-1] != bus.in0[WIDTH-1]);
  assign slt_s   = sum_s[WIDTH-1] ^ ovf_s;
  assign shamt_s = bus.in1[SHAMT_W-1:0];
  assign first_s = shift_step(bus.op, bus.in0);
  assign iter_s  = shift_step(op_r, result_r);

  // Next-state and next-output computation.
  always_comb begin
    state_nxt_s    = state_r;
    op_nxt_s       = op_r;
    cnt_nxt_s      = cnt_r;
    result_nxt_s   = result_r;
    carry_nxt_s    = carry_r;
    overflow_nxt_s = overflow_r;
    illegal_nxt_s  = illegal_r;
    case (state_r)
      S_SHIFT: begin
        result_nxt_s = iter_s[WIDTH-1:0];
        carry_nxt_s  = iter_s[WIDTH];
        cnt_nxt_s    = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_SHIFT;
        end
      end
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          op_nxt_s       = bus.op;
          state_nxt_s    = S_DONE;
          carry_nxt_s    = 1'b0;
          overflow_nxt_s = 1'b0;
          illegal_nxt_s  = 1'b0;
          case (bus.op)
            OP_AND: result_nxt_s = bus.in0 & bus.in1;
            OP_OR:  result_nxt_s = bus.in0 | bus.in1;
            OP_NOR: result_nxt_s = ~(bus.in0 | bus.in1);
            OP_SLT: result_nxt_s = {{(WIDTH-1){1'b0}}, slt_s};
            OP_ADD, OP_SUB: begin
              result_nxt_s   = sum_s[WIDTH-1:0];
              carry_nxt_s    = sum_s[WIDTH];
              overflow_nxt_s = ovf_s;
            end
`ifdef ALU_ITER_SRA_EN
            OP_SRL, OP_SLL, OP_SRA: begin
`else
            OP_SRL, OP_SLL: begin
`endif
              // The first bit moves on the accept edge, so SHIFT lasts shamt-1 cycles.
              if (shamt_s == CNT_ZERO) begin
                result_nxt_s = bus.in0;
              end else begin
                result_nxt_s = first_s[WIDTH-1:0];
                carry_nxt_s  = first_s[WIDTH];
                cnt_nxt_s    = shamt_s - CNT_ONE;
                if (shamt_s == CNT_ONE) begin
                  state_nxt_s = S_DONE;
                end else begin
                  state_nxt_s = S_SHIFT;
                end
              end
            end
            default: begin
              result_nxt_s  = {WIDTH{1'b0}};
              illegal_nxt_s = 1'b1;
            end
          endcase
        end else if ((state_r == S_DONE) && bus.out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
    zero_nxt_s = ~|result_nxt_s;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      op_r       <= 4'b0000;
      cnt_r      <= CNT_ZERO;
      result_r   <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      overflow_r <= 1'b0;
      zero_r     <= 1'b0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      op_r       <= op_nxt_s;
      cnt_r      <= cnt_nxt_s;
      result_r   <= result_nxt_s;
      carry_r    <= carry_nxt_s;
      overflow_r <= overflow_nxt_s;
      zero_r     <= zero_nxt_s;
      illegal_r  <= illegal_nxt_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == S_DONE);
  assign bus.busy      = (state_r == S_SHIFT);
  assign bus.result    = result_r;
  assign bus.carry     = carry_r;
  assign bus.overflow  = overflow_r;
  assign bus.zero      = zero_r;
  assign bus.illegal   = illegal_r;
endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: expected results are queued at issue and
// compared by a monitor on every result handshake.
module tb_alu_iter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_iter_if #(.WIDTH(W)) ifc ();
  alu_iter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct packed {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic        il;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [32:0] s;
    int sh;
    e  = '0;
    sh = int'(b[4:0]);
    case (op)
      4'h0: e.res = a & b;
      4'h1: e.res = a | b;
      4'h2: begin
        s = {1'b0, a} + {1'b0, b};
        e.res = s[31:0];
        e.c = s[32];
        e.v = (a[31] == b[31]) && (s[31] != a[31]);
      end
      4'h3: begin
        s = {1'b0, a} - {1'b0, b};
        e.res = s[31:0];
        e.c = (a >= b);
        e.v = (a[31] != b[31]) && (s[31] != a[31]);
      end
      4'h4: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h5: e.res = ~(a | b);
      4'h6: begin
        e.res = a >> sh;
        e.c = (sh == 0) ? 1'b0 : a[sh-1];
      end
      4'h7: begin
        e.res = a << sh;
        e.c = (sh == 0) ? 1'b0 : a[32-sh];
      end
`ifdef ALU_ITER_SRA_EN
      4'h8: begin
        e.res = $signed(a) >>> sh;
        e.c = (sh == 0) ? 1'b0 : a[sh-1];
      end
`endif
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic int lat_of(input logic [3:0] op, input logic [31:0] b);
    logic sh_op;
    sh_op = (op == 4'h6) || (op == 4'h7);
`ifdef ALU_ITER_SRA_EN
    sh_op = sh_op || (op == 4'h8);
`endif
    if (sh_op && (b[4:0] != 5'd0)) return int'(b[4:0]);
    return 1;
  endfunction

  // Result monitor: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("result",   ifc.result, mon_e.res);
        chk("carry",    {31'd0, ifc.carry},    {31'd0, mon_e.c});
        chk("overflow", {31'd0, ifc.overflow}, {31'd0, mon_e.v});
        chk("zero",     {31'd0, ifc.zero},     {31'd0, mon_e.z});
        chk("illegal",  {31'd0, ifc.illegal},  {31'd0, mon_e.il});
      end
    end
  end

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int lat, busy_n, rdy_n, exp_lat;
    sb_q.push_back(model(op, a, b));
    exp_lat = lat_of(op, b);
    ifc.in_valid = 1'b1;
    ifc.op = op;
    ifc.in0 = a;
    ifc.in1 = b;
    @(negedge clk);
    chk("in_ready_accept", {31'd0, ifc.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    ifc.op = 4'h0;
    ifc.in0 = ~a;
    ifc.in1 = ~b;
    lat = 1;
    busy_n = 0;
    rdy_n = 0;
    @(negedge clk);
    while (!ifc.out_valid && lat < 100) begin
      if (ifc.busy) busy_n++;
      if (ifc.in_ready) rdy_n++;
      lat++;
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("busy_cycles", busy_n, exp_lat - 1);
    chk("in_ready_in_shift", rdy_n, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held;
    int stale;
    logic [3:0] rop;
    rst = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.op = 4'h0;
    ifc.in0 = 32'd0;
    ifc.in1 = 32'd0;
    ifc.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, ifc.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("rst_busy",      {31'd0, ifc.busy},      32'd0);
    chk("rst_result",    ifc.result,             32'd0);
    chk("rst_flags", {28'd0, ifc.carry, ifc.overflow, ifc.zero, ifc.illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_op(4'h2, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(4'h3, 32'h8000_0000, 32'h0000_0001);
    run_op(4'h4, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op(4'h4, 32'h0000_0001, 32'hFFFF_FFFF);
    run_op(4'h7, 32'h0000_0001, 32'h0000_002F);
    run_op(4'h6, 32'h8000_0001, 32'h0000_0001);
    run_op(4'h7, 32'h0000_ABCD, 32'h0000_0020);
    run_op(4'h6, 32'hC000_0000, 32'h0000_001F);
    run_op(4'h2, 32'h7FFF_FFFF, 32'h0000_0001);
    run_op(4'h3, 32'h0000_0005, 32'h0000_0005);
    run_op(4'h5, 32'h1234_5678, 32'h0F0F_0000);
    run_op(4'h8, 32'h8000_0000, 32'h0000_0004);
    run_op(4'h8, 32'h9000_0001, 32'h0000_0003);
    run_op(4'hF, 32'h1234_5678, 32'h0000_0001);

    // Backpressure: result held, then drained on the same edge a new op is accepted.
    ifc.out_ready = 1'b0;
    run_op(4'h1, 32'h1234_5678, 32'h0F0F_0000);
    held = ifc.result;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result_stable", ifc.result, held);
      chk("bp_in_ready", {31'd0, ifc.in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, ifc.out_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    ifc.out_ready = 1'b1;
    ifc.in_valid = 1'b1;
    ifc.op = 4'h0;
    ifc.in0 = 32'hF0F0_F0F0;
    ifc.in1 = 32'hFF00_FF00;
    sb_q.push_back(model(4'h0, 32'hF0F0_F0F0, 32'hFF00_FF00));
    @(negedge clk);
    chk("bp_in_ready_release", {31'd0, ifc.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    chk("bp_next_valid", {31'd0, ifc.out_valid}, 32'd1);
    chk("bp_next_result", ifc.result, 32'hF000_F000);
    @(posedge clk);
    #1;

    // Back-to-back single-cycle ops with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(5));
      ifc.in_valid = 1'b1;
      ifc.op = rop;
      ifc.in0 = $urandom;
      ifc.in1 = $urandom;
      sb_q.push_back(model(rop, ifc.in0, ifc.in1));
      @(negedge clk);
      chk("b2b_in_ready", {31'd0, ifc.in_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    ifc.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;

    // Reset in the middle of a long shift: nothing may be presented afterwards.
    ifc.in_valid = 1'b1;
    ifc.op = 4'h7;
    ifc.in0 = 32'h0000_0001;
    ifc.in1 = 32'h0000_001F;
    @(posedge clk);
    #1;
    ifc.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", {31'd0, ifc.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, ifc.out_valid}, 32'd0);
    chk("mid_rst_in_ready",  {31'd0, ifc.in_ready},  32'd1);
    chk("mid_rst_busy",      {31'd0, ifc.busy},      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ifc.out_valid) stale++;
    end
    chk("no_stale_result", stale, 0);
    @(posedge clk);
    #1;

    run_op(4'h6, 32'hDEAD_BEEF, 32'hFFFF_FFE4);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
